edge_to_level: RTL and testbench

//  Rebuilds a level signal from single-cycle rising/falling edge event pulses.
//  It is the inverse of the edge detector. Detector outputs pos_edge/neg_edge

---
 rtl/edge_to_level.sv | 168 ++++++++++++++++
 tb/tb_edge_to_level.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/edge_to_level.sv
// Rebuilds a level waveform from rising/falling edge event pulses, enforcing minimum
// high/low widths, deferring edges seen during a hold and flagging illegal sequences.
module edge_to_level #(
    parameter int unsigned MIN_HIGH = 3,
    parameter int unsigned MIN_LOW  = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pos_edge,
    input  logic             neg_edge,
    input  logic             err_clr,
    output logic             data,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] pos_cnt,
    output logic [CNT_W-1:0] neg_cnt
);

    localparam int unsigned MaxHold = (MIN_HIGH > MIN_LOW) ? MIN_HIGH : MIN_LOW;
    localparam int unsigned HoldW   = (MaxHold > 1) ? $clog2(MaxHold) : 1;
    localparam logic [HoldW-1:0] HighLast = HoldW'(MIN_HIGH - 1);
    localparam logic [HoldW-1:0] LowLast  = HoldW'(MIN_LOW - 1);

    typedef enum logic [1:0] {
        StLow,
        StHighHold,
        StHigh,
        StLowHold
    } state_e;

    state_e             state_q, state_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic               pend_q, pend_d;
    logic               data_q, data_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   pos_cnt_q, pos_cnt_d;
    logic [CNT_W-1:0]   neg_cnt_q, neg_cnt_d;
    logic               illegal;
    logic               inc_pos;
    logic               inc_neg;
    logic               both;

    assign both = pos_edge & neg_edge;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pend_d  = pend_q;
        illegal = 1'b0;
        inc_pos = 1'b0;
        inc_neg = 1'b0;

        case (state_q)
            StLow: begin
                if (both || neg_edge) begin
                    illegal = 1'b1;
                end else if (pos_edge) begin
                    state_d = StHighHold;
                    hold_d  = '0;
                    pend_d  = 1'b0;
                    inc_pos = 1'b1;
                end
            end

            StHighHold: begin
                if (both) begin
                    illegal = 1'b1;
                end else if (neg_edge) begin
                    pend_d = 1'b1;
                end else if (pos_edge) begin
                    // A rise while a fall is pending cancels it as a glitch.
                    if (pend_q) pend_d = 1'b0;
                    else        illegal = 1'b1;
                end
                if (hold_q == HighLast) begin
                    hold_d = '0;
                    if (pend_d) begin
                        state_d = StLowHold;
                        pend_d  = 1'b0;
                        inc_neg = 1'b1;
                    end else begin
                        state_d = StHigh;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            StHigh: begin
                if (both || pos_edge) begin
                    illegal = 1'b1;
                end else if (neg_edge) begin
                    state_d = StLowHold;
                    hold_d  = '0;
                    pend_d  = 1'b0;
                    inc_neg = 1'b1;
                end
            end

            StLowHold: begin
                if (both) begin
                    illegal = 1'b1;
                end else if (pos_edge) begin
                    pend_d = 1'b1;
                end else if (neg_edge) begin
                    if (pend_q) pend_d = 1'b0;
                    else        illegal = 1'b1;
                end
                if (hold_q == LowLast) begin
                    hold_d = '0;
                    if (pend_d) begin
                        state_d = StHighHold;
                        pend_d  = 1'b0;
                        inc_pos = 1'b1;
                    end else begin
                        state_d = StLow;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            default: begin
                state_d = StLow;
                hold_d  = '0;
                pend_d  = 1'b0;
            end
        endcase

        data_d    = (state_d == StHighHold) || (state_d == StHigh);
        busy_d    = (state_d == StHighHold) || (state_d == StLowHold);
        // A new illegal event in the same cycle beats the clear.
        err_d     = illegal ? 1'b1 : (err_clr ? 1'b0 : err_q);
        pos_cnt_d = inc_pos ? pos_cnt_q + 1'b1 : pos_cnt_q;
        neg_cnt_d = inc_neg ? neg_cnt_q + 1'b1 : neg_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StLow;
            hold_q    <= '0;
            pend_q    <= 1'b0;
            data_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            pos_cnt_q <= '0;
            neg_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            pend_q    <= pend_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            pos_cnt_q <= pos_cnt_d;
            neg_cnt_q <= neg_cnt_d;
        end
    end

    assign data    = data_q;
    assign busy    = busy_q;
    assign err     = err_q;
    assign pos_cnt = pos_cnt_q;
    assign neg_cnt = neg_cnt_q;

endmodule

// File: tb/tb_edge_to_level.sv
// Directed bench for edge_to_level: default-parameter instance plus a CNT_W=2
// instance for counter wrap and mid-hold reset.
module tb_edge_to_level;

    logic       clk = 1'b0;
    logic       rst_n, pos_edge, neg_edge, err_clr;
    logic       data, busy, err;
    logic [7:0] pos_cnt, neg_cnt;

    logic       rst2_n, pos2, neg2;
    logic       data2, busy2, err2;
    logic [1:0] pos_cnt2, neg_cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    edge_to_level dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pos_edge (pos_edge),
        .neg_edge (neg_edge),
        .err_clr  (err_clr),
        .data     (data),
        .busy     (busy),
        .err      (err),
        .pos_cnt  (pos_cnt),
        .neg_cnt  (neg_cnt)
    );

    edge_to_level #(.MIN_HIGH(3), .MIN_LOW(2), .CNT_W(2)) dut_w (
        .clk      (clk),
        .rst_n    (rst2_n),
        .pos_edge (pos2),
        .neg_edge (neg2),
        .err_clr  (1'b0),
        .data     (data2),
        .busy     (busy2),
        .err      (err2),
        .pos_cnt  (pos_cnt2),
        .neg_cnt  (neg_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse2();
        pos2 = 1'b1; tick(); pos2 = 1'b0;
        repeat (3) tick();
        neg2 = 1'b1; tick(); neg2 = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        rst_n = 1'b0; pos_edge = 1'b0; neg_edge = 1'b0; err_clr = 1'b0;
        rst2_n = 1'b0; pos2 = 1'b0; neg2 = 1'b0;

        // 1: reset
        tick(); tick();
        check("rst_data", data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_pcnt", pos_cnt, 0);
        check("rst_ncnt", neg_cnt, 0);
        rst_n = 1'b1; rst2_n = 1'b1;
        tick();

        // 2: pos, then neg long after the hold
        pos_edge = 1'b1; tick(); pos_edge = 1'b0;
        check("t2_c3_data", data, 1);
        check("t2_c3_busy", busy, 1);
        tick(); tick();
        check("t2_c5_busy", busy, 1);
        tick();
        check("t2_c6_busy", busy, 0);
        check("t2_c6_data", data, 1);
        tick(); tick();
        check("t2_c8_data", data, 1);
        neg_edge = 1'b1; tick(); neg_edge = 1'b0;
        check("t2_c9_data", data, 0);
        check("t2_c9_busy", busy, 1);
        check("t2_pcnt", pos_cnt, 1);
        check("t2_ncnt", neg_cnt, 1);
        check("t2_err", err, 0);
        tick(); tick();
        check("t2_idle_busy", busy, 0);

        // 3: fall during high hold is deferred
        pos_edge = 1'b1; tick(); pos_edge = 1'b0;
        neg_edge = 1'b1; tick(); neg_edge = 1'b0;
        check("t3_c4_data", data, 1);
        tick();
        check("t3_c5_data", data, 1);
        check("t3_c5_ncnt", neg_cnt, 1);
        tick();
        check("t3_c6_data", data, 0);
        check("t3_c6_busy", busy, 1);
        check("t3_c6_ncnt", neg_cnt, 2);
        tick();
        check("t3_c7_busy", busy, 1);
        tick();
        check("t3_c8_busy", busy, 0);
        check("t3_err", err, 0);

        // 4: neg then pos within hold is a glitch
        pos_edge = 1'b1; tick(); pos_edge = 1'b0;
        neg_edge = 1'b1; tick(); neg_edge = 1'b0;
        pos_edge = 1'b1; tick(); pos_edge = 1'b0;
        check("t4_c5_data", data, 1);
        tick();
        check("t4_c6_data", data, 1);
        check("t4_c6_busy", busy, 0);
        check("t4_ncnt", neg_cnt, 2);
        check("t4_pcnt", pos_cnt, 3);
        check("t4_err", err, 0);
        // pos while HIGH is illegal and ignored
        pos_edge = 1'b1; tick(); pos_edge = 1'b0;
        check("t4_highpos_err", err, 1);
        check("t4_highpos_pcnt", pos_cnt, 3);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("t4_clr", err, 0);
        neg_edge = 1'b1; tick(); neg_edge = 1'b0;
        check("t4_fall", data, 0);
        check("t4_fall_ncnt", neg_cnt, 3);
        tick(); tick();

        // 5: simultaneous edges, err_clr, neg while LOW
        pos_edge = 1'b1; neg_edge = 1'b1; tick(); pos_edge = 1'b0; neg_edge = 1'b0;
        check("t5_c3_data", data, 0);
        check("t5_c3_err", err, 1);
        check("t5_pcnt", pos_cnt, 3);
        tick();
        check("t5_c4_err", err, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("t5_c6_err", err, 0);
        tick();
        neg_edge = 1'b1; tick(); neg_edge = 1'b0;
        check("t5_lowneg_err", err, 1);
        err_clr = 1'b1; neg_edge = 1'b1; tick(); err_clr = 1'b0; neg_edge = 1'b0;
        check("t5_setwins", err, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("t5_clr2", err, 0);

        // 6: counter wrap and reset mid-hold on the CNT_W=2 instance
        pulse2(); pulse2(); pulse2();
        check("t6_pcnt3", pos_cnt2, 3);
        check("t6_ncnt3", neg_cnt2, 3);
        pulse2();
        check("t6_pwrap", pos_cnt2, 0);
        check("t6_nwrap", neg_cnt2, 0);
        check("t6_err", err2, 0);
        pos2 = 1'b1; tick(); pos2 = 1'b0;
        check("t6_hold_data", data2, 1);
        check("t6_hold_pcnt", pos_cnt2, 1);
        rst2_n = 1'b0; tick(); rst2_n = 1'b1;
        check("t6_rst_data", data2, 0);
        check("t6_rst_busy", busy2, 0);
        check("t6_rst_pcnt", pos_cnt2, 0);
        check("t6_rst_ncnt", neg_cnt2, 0);
        tick(); tick(); tick();
        check("t6_stays_low", data2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
